// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM states and iteration count for the multiply/divide unit.
// Opcode values match the ALU's aluc field so decode needs no translation.
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [5:0] MULTU = 6'b010001;
  localparam logic [5:0] MULT  = 6'b010011;
  localparam logic [5:0] DIVU  = 6'b010000;
  localparam logic [5:0] DIV   = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic op_valid(input logic [5:0] op);
    return (op == MULTU) || (op == MULT) || (op == DIVU) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational two's-complement negate of a hi/lo pair, either as one 2W-bit value or as two W-bit halves.
// Zero latency; no flow control, purely a function of its inputs.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic         wide_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [2*W-1:0] pair;
  logic [2*W-1:0] pair_neg;

  assign pair     = {hi_i, lo_i};
  assign pair_neg = -pair;

  // In wide mode neg_hi_i carries the sign of the whole 2W-bit value.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (wide_i) begin
      if (neg_hi_i) begin
        {hi_o, lo_o} = pair_neg;
      end
    end else begin
      if (neg_hi_i) hi_o = -hi_i;
      if (neg_lo_i) lo_o = -lo_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide into HI/LO, one bit per cycle; result visible 33 cycles after accepting start.
// No backpressure: start is only sampled in IDLE, issue stalls on busy, flush aborts without touching HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      aluc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam int AW = 2 * XLEN + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_hi_q, neg_hi_d;
  logic            neg_lo_q, neg_lo_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            op_signed;
  logic            op_is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  logic [XLEN:0]   mul_upper;
  logic [AW-1:0]   mul_next;
  logic [AW-1:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [AW-1:0]   div_next;

  assign op_signed = (aluc == MULT) || (aluc == DIV);
  assign op_is_div = (aluc == DIVU) || (aluc == DIV);
  assign sgn_a     = op_signed & a[XLEN-1];
  assign sgn_b     = op_signed & b[XLEN-1];

  muldiv_signfix #(.W(XLEN)) u_opnd_fix (
    .hi_i     (a),
    .lo_i     (b),
    .neg_hi_i (sgn_a),
    .neg_lo_i (sgn_b),
    .wide_i   (1'b0),
    .hi_o     (a_mag),
    .lo_o     (b_mag)
  );

  // Remainder sits in acc[63:32]; it is always below the divisor so fits in XLEN bits.
  muldiv_signfix #(.W(XLEN)) u_res_fix (
    .hi_i     (acc_q[2*XLEN-1:XLEN]),
    .lo_i     (acc_q[XLEN-1:0]),
    .neg_hi_i (neg_hi_q),
    .neg_lo_i (neg_lo_q),
    .wide_i   (~is_div_q),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  // Shift-add step: acc = {upper 33 bits, multiplier}, multiplicand held in opnd_q.
  assign mul_upper = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign mul_next  = {1'b0, mul_upper, acc_q[XLEN-1:1]};

  // Restoring step: acc = {remainder, quotient}, divisor held in opnd_q.
  assign div_shift = {acc_q[AW-2:0], 1'b0};
  assign div_trial = div_shift[AW-1:XLEN] - {1'b0, opnd_q};
  assign div_next  = div_trial[XLEN] ? div_shift
                                     : {div_trial, div_shift[XLEN-1:1], 1'b1};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && op_valid(aluc)) begin
          state_d  = CALC;
          cnt_d    = CW'(ITER - 1);
          is_div_d = op_is_div;
          if (op_is_div) begin
            acc_d    = {{(XLEN+1){1'b0}}, a_mag};
            opnd_d   = b_mag;
            neg_lo_d = sgn_a ^ sgn_b;
            neg_hi_d = sgn_a;
          end else begin
            acc_d    = {{(XLEN+1){1'b0}}, b_mag};
            opnd_d   = a_mag;
            neg_lo_d = sgn_a ^ sgn_b;
            neg_hi_d = sgn_a ^ sgn_b;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = FIN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
          dbz_d  = is_div_q && (opnd_q == '0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
